deserializer: RTL

- Downstream neighbour of the serializer stage: consumes its serial bit stream and rebuilds parallel words.
- Collects WORD_LEN valid serial bits into a word and emits it with a one-cycle valid pulse.
- A gap watchdog discards a partially received word when the serial stream stalls for too long mid-word.
- Sits between the serializer output (ser_data_o / ser_data_val_o) and any parallel consumer (checker, FIFO).

---
 rtl/deser_pkg.sv | 17 +
 rtl/deser_gap_timer.sv | 35 +++
 rtl/deserializer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer slice:
// default geometry, FSM state encoding and counter width helpers.
package deser_pkg;

  localparam int DESER_WORD_LEN_DEF    = 16;
  localparam int DESER_GAP_TIMEOUT_DEF = 8;

  // Counter widths for the default geometry; instances derive their own.
  localparam int DESER_BCNT_W = $clog2(DESER_WORD_LEN_DEF + 1);
  localparam int DESER_GCNT_W = $clog2(DESER_GAP_TIMEOUT_DEF + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_gap_timer.sv
// Gap watchdog for serial links: counts consecutive idle cycles while
// enabled and raises a single-cycle expire pulse when the idle run reaches
// GAP_TIMEOUT. A kick in the would-be expiry cycle suppresses the pulse.
module deser_gap_timer
  import deser_pkg::*;
#(
  parameter int GAP_TIMEOUT = DESER_GAP_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int GCNT_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GCNT_W-1:0] GAP_LAST = GCNT_W'(GAP_TIMEOUT - 1);

  logic [GCNT_W-1:0] gap_cnt_q;

  // The idle cycle that would bring the count to GAP_TIMEOUT is the expiry cycle.
  assign expire = enable && !kick && (gap_cnt_q == GAP_LAST);

  // Idle-run counter; held at zero when disabled, kicked or just expired.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gap_cnt_q <= '0;
    end else if (!enable || kick || expire) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_q + GCNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: gathers WORD_LEN valid serial bits into
// a word, presents it with a one-cycle valid pulse and drops partial words
// when the stream stalls mid-word for GAP_TIMEOUT cycles.
// Build option: define DESER_LSB_FIRST_EN to place the first received bit in
// deser_data_o[0]; by default the first bit lands in the MSB.
module deserializer
  import deser_pkg::*;
#(
  parameter int WORD_LEN    = DESER_WORD_LEN_DEF,
  parameter int GAP_TIMEOUT = DESER_GAP_TIMEOUT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                data_i,
  input  logic                data_val_i,
  output logic [WORD_LEN-1:0] deser_data_o,
  output logic                deser_data_val_o,
  output logic                busy_o,
  output logic                drop_o
);

  localparam int BCNT_W = $clog2(WORD_LEN + 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(WORD_LEN - 1);

  deser_state_t        state_q, state_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_LEN-1:0] shift_q, shift_d;
  logic [WORD_LEN-1:0] shift_next;
  logic                word_done;
  logic                gap_expire;

  // Insert one serial bit into the partial word in the configured bit order.
  function automatic logic [WORD_LEN-1:0] shift_in(input logic [WORD_LEN-1:0] cur,
                                                    input logic bit_in);
`ifdef DESER_LSB_FIRST_EN
    return {bit_in, cur[WORD_LEN-1:1]};
`else
    return {cur[WORD_LEN-2:0], bit_in};
`endif
  endfunction

  assign shift_next = shift_in(shift_q, data_i);
  assign busy_o     = (state_q == RECV);

  deser_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .enable (state_q == RECV),
    .kick   (data_val_i),
    .expire (gap_expire)
  );

  // Next-state logic: count bits, complete on the last one, abandon on expiry.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_val_i) begin
          state_d   = RECV;
          bit_cnt_d = BCNT_W'(1);
          shift_d   = shift_next;
        end
      end
      RECV: begin
        if (data_val_i) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            shift_d   = shift_next;
          end
        end else if (gap_expire) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  // FSM state, bit counter and partial-word shift register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Registered outputs: word load with valid pulse, and the drop pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
      drop_o           <= 1'b0;
    end else begin
      deser_data_val_o <= word_done;
      drop_o           <= gap_expire;
      if (word_done) begin
        deser_data_o <= shift_next;
      end
    end
  end

endmodule
